// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: operand/control bus from ID/EX and result bus to EX/MEM for the multiply/divide unit
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  modport master (
    output start_i, flush_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  stall_o, done_o, result_o, rd_addr_o
  );
  modport slave (
    input  start_i, flush_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output stall_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit (divider present only when EX_MULDIV_DIV_EN is defined)
module ex_muldiv #(parameter int XLEN = 32) (
  input logic        clk_i,
  input logic        rst_i,
  ex_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [XLEN-1:0]   r_op;
  logic [2*XLEN-1:0] r_acc;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;
  logic [XLEN-1:0]   w_a, w_b, w_abs_a, w_abs_b, w_mul_res, w_fix_res, w_spec_res;
  logic              w_sa, w_sb, w_neg, w_div, w_go, w_spec;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod;
`ifdef EX_MULDIV_DIV_EN
  logic [XLEN-1:0]   r_rem;
  logic [XLEN:0]     w_shift, w_trial;
  logic [XLEN-1:0]   w_div_mag, w_div_res;
  logic              w_b_zero, w_ovf;
`endif
  assign w_a = bus.rs1_data_i;
  assign w_b = bus.rs2_data_i;
  assign w_go = bus.start_i & !bus.flush_i;
  assign w_div = bus.funct3_i[2];
  // operand magnitudes and result sign; only signed operand positions contribute a sign
  always_comb begin
    w_sa = (bus.funct3_i == 3'd1) | (bus.funct3_i == 3'd2) | (bus.funct3_i == 3'd4) | (bus.funct3_i == 3'd6);
    w_sb = (bus.funct3_i == 3'd1) | (bus.funct3_i == 3'd4) | (bus.funct3_i == 3'd6);
    w_abs_a = (w_sa & w_a[XLEN-1]) ? -w_a : w_a;
    w_abs_b = (w_sb & w_b[XLEN-1]) ? -w_b : w_b;
    w_neg = (bus.funct3_i == 3'd6) ? w_a[XLEN-1] : ((w_sa & w_a[XLEN-1]) ^ (w_sb & w_b[XLEN-1]));
  end
  // shift-add step: add multiplicand into the upper half when the current multiplier bit is set
  always_comb begin
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    w_prod = r_neg ? -r_acc : r_acc;
    w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end
`ifdef EX_MULDIV_DIV_EN
  // restoring divide step, sign fix-up and the early-out special cases
  always_comb begin
    w_shift = {r_rem, r_acc[XLEN-1]};
    w_trial = w_shift - {1'b0, r_op};
    w_div_mag = r_f3[1] ? r_rem : r_acc[XLEN-1:0];
    w_div_res = r_neg ? -w_div_mag : w_div_mag;
    w_fix_res = r_f3[2] ? w_div_res : w_mul_res;
    w_b_zero = (w_b == '0);
    w_ovf = !bus.funct3_i[0] & (w_a == MIN) & (w_b == '1);
    w_spec = w_div & (w_b_zero | w_ovf);
    w_spec_res = w_b_zero ? (bus.funct3_i[1] ? w_a : '1) : (bus.funct3_i[1] ? '0 : MIN);
  end
`else
  // without a divider every divide op finishes immediately with zero
  always_comb begin
    w_fix_res = r_f3[2] ? '0 : w_mul_res;
    w_spec = w_div;
    w_spec_res = '0;
  end
`endif
  assign bus.stall_o = !rst_i & (((r_state == IDLE) & w_go) | (r_state == BUSY) | (r_state == FIX));
  assign bus.done_o = r_done;
  assign bus.result_o = r_result;
  assign bus.rd_addr_o = r_rd_out;
  // control FSM with iteration datapath and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_f3 <= '0;
      r_rd <= '0;
      r_neg <= 1'b0;
      r_op <= '0;
      r_acc <= '0;
      r_done <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
`ifdef EX_MULDIV_DIV_EN
      r_rem <= '0;
`endif
    end else if (bus.flush_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_f3 <= bus.funct3_i;
            r_rd <= bus.rd_addr_i;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_spec) begin
              r_result <= w_spec_res;
              r_rd_out <= bus.rd_addr_i;
              r_done <= 1'b1;
              r_state <= DONE;
            end else begin
              r_op <= w_div ? w_abs_b : w_abs_a;
              r_acc <= {{XLEN{1'b0}}, w_div ? w_abs_a : w_abs_b};
`ifdef EX_MULDIV_DIV_EN
              r_rem <= '0;
`endif
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef EX_MULDIV_DIV_EN
          if (r_f3[2]) begin
            r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
            r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], !w_trial[XLEN]};
          end else
`endif
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
          if (r_cnt == CW'(XLEN - 1)) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fix_res;
          r_rd_out <= r_rd;
          r_done <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0] last_rd = '0;
  ex_muldiv_if bus();
  ex_muldiv dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
`ifndef EX_MULDIV_DIV_EN
    if (f3[2]) return 32'd0;
`endif
    case (f3)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULDIV_DIV_EN
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`else
    if (f3[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input string tag);
    logic [31:0] exp_res;
    int lat;
    exp_res = ref_res(f3, a, b);
    lat = ref_lat(f3, a, b);
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.start_i = 1'b1; bus.funct3_i = f3; bus.rs1_data_i = a; bus.rs2_data_i = b; bus.rd_addr_i = rd;
      end else begin
        bus.start_i = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.funct3_i = 3'($urandom); bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom; bus.rd_addr_i = 5'($urandom);
      end
      #1;
      n_cmp++;
      if (bus.stall_o !== (k < lat)) begin n_err++; $display("FAIL %s stall cyc %0d got %b exp %b", tag, k, bus.stall_o, k < lat); end
      n_cmp++;
      if (bus.done_o !== (k == lat)) begin n_err++; $display("FAIL %s done cyc %0d got %b exp %b", tag, k, bus.done_o, k == lat); end
      if (k == lat) begin
        n_cmp++;
        if (bus.result_o !== exp_res) begin n_err++; $display("FAIL %s result f3=%0d a=%h b=%h got %h exp %h", tag, f3, a, b, bus.result_o, exp_res); end
        n_cmp++;
        if (bus.rd_addr_o !== rd) begin n_err++; $display("FAIL %s rd got %0d exp %0d", tag, bus.rd_addr_o, rd); end
      end else begin
        n_cmp++;
        if (bus.result_o !== last_res) begin n_err++; $display("FAIL %s held result cyc %0d got %h exp %h", tag, k, bus.result_o, last_res); end
      end
    end
    bus.start_i = 1'b0;
    last_res = exp_res;
    last_rd = rd;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      n_cmp++;
      if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin n_err++; $display("FAIL %s idle cyc %0d stall %b done %b exp 0 0", tag, k, bus.stall_o, bus.done_o); end
      n_cmp++;
      if (bus.result_o !== last_res || bus.rd_addr_o !== last_rd) begin n_err++; $display("FAIL %s idle hold got %h/%0d exp %h/%0d", tag, bus.result_o, bus.rd_addr_o, last_res, last_rd); end
    end
  endtask

  task automatic test_reset;
    bus.start_i = 1'b1; bus.flush_i = 1'b0; bus.funct3_i = 3'd0; bus.rs1_data_i = 32'd3; bus.rs2_data_i = 32'd5; bus.rd_addr_i = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset ctrl stall %b done %b exp 0 0", bus.stall_o, bus.done_o); end
      n_cmp++;
      if (bus.result_o !== 32'd0 || bus.rd_addr_o !== 5'd0) begin n_err++; $display("FAIL reset data got %h/%0d exp 0/0", bus.result_o, bus.rd_addr_o); end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(3, "post_reset");
  endtask

  task automatic test_mul;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_neg");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, "mulhsu");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, "mulh_min");
    run_op(3'd1, 32'hFFFF_FFF9, 32'd3, 5'd9, "mulh_neg");
  endtask

  task automatic test_div;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, "rem_neg");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd7, 5'd12, "divu");
    run_op(3'd7, 32'hFFFF_FFFF, 32'd7, 5'd13, "remu");
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd14, "rem_negdiv");
  endtask

  task automatic test_special;
    run_op(3'd5, 32'd5, 32'd0, 5'd15, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 5'd16, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, "rem_ovf");
    run_op(3'd4, 32'h1234_5678, 32'd0, 5'd19, "div_by0");
  endtask

  task automatic flush_at(input logic [2:0] f3, input int kf, input string tag);
    for (int k = 0; k <= kf + 1; k++) begin
      @(posedge clk); #1;
      bus.start_i = (k == 0);
      bus.flush_i = (k == kf);
      if (k == 0) begin bus.funct3_i = f3; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd7; bus.rd_addr_i = 5'd20; end
      #1;
      n_cmp++;
      if (bus.stall_o !== (k <= kf) || bus.done_o !== 1'b0) begin n_err++; $display("FAIL %s cyc %0d stall %b done %b exp %b 0", tag, k, bus.stall_o, bus.done_o, k <= kf); end
      n_cmp++;
      if (bus.result_o !== last_res) begin n_err++; $display("FAIL %s result cyc %0d got %h exp %h", tag, k, bus.result_o, last_res); end
    end
    idle_check(36, tag);
  endtask

  task automatic test_flush;
`ifdef EX_MULDIV_DIV_EN
    flush_at(3'd5, 10, "flush_divu");
`else
    flush_at(3'd3, 10, "flush_mulhu");
`endif
    flush_at(3'd0, 33, "flush_fix");
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'd0;
    #1;
    n_cmp++;
    if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL flush_start stall got %b exp 0", bus.stall_o); end
    idle_check(36, "flush_start");
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      bus.start_i = (k == 0);
      if (k == 0) begin bus.funct3_i = 3'd0; bus.rs1_data_i = 32'd123; bus.rs2_data_i = 32'd456; bus.rd_addr_i = 5'd21; end
      if (k == 20) rst = 1'b1;
      #1;
    end
    n_cmp++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0 || bus.rd_addr_o !== 5'd0)
      begin n_err++; $display("FAIL mid_reset got stall %b done %b res %h rd %0d exp 0 0 0 0", bus.stall_o, bus.done_o, bus.result_o, bus.rd_addr_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    last_rd = '0;
    idle_check(36, "mid_reset_idle");
    run_op(3'd0, 32'd3, 32'd4, 5'd22, "mul_after_reset");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), "random");
  endtask

  initial begin
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.rd_addr_i = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
